// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Owns the program counter, drives the address of a
// synchronous-read instruction memory (one-cycle read latency) and pairs each
// returned word with its PC before offering it to decode. A one-entry hold
// buffer catches the offered word when decode stalls, so nothing is lost or
// duplicated. A redirect from execute squashes the offered word and restarts
// fetch at the target.
//
// Handshake: id_valid/id_ready. A transfer happens on a rising edge where
// id_valid && id_ready. Once id_valid is raised, id_pc/id_instr stay stable
// until the transfer, unless a redirect or reset squashes the offer.
//
// Optional build macro: FETCH_FAST_REDIRECT_EN
//   defined   - the redirect target goes straight to imem_addr in the redirect
//               cycle (one bubble), at the cost of a redirect_pc -> imem_addr
//               combinational path.
//   undefined - imem_addr is purely registered (two bubbles per redirect).
//
// Ports
//   clk               in   clock, all state on rising edge
//   rst_n             in   synchronous active-low reset
//   imem_addr         out  address to instruction memory
//   imem_instruction  in   word at the address presented the previous cycle
//   redirect_valid    in   taken branch/jump resolved this cycle
//   redirect_pc       in   redirect target, bits [1:0] ignored
//   id_valid          out  an instruction is offered to decode
//   id_ready          in   decode accepts this cycle
//   id_pc             out  PC of the offered instruction
//   id_instr          out  offered instruction (NOP_INSTR when id_valid=0)
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  // Next address to issue to memory.
  logic [31:0] pc_q, pc_d;
  // Tag for the word currently coming back from memory.
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  // Skid entry holding the word offered when decode stalled.
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  logic [31:0] redirect_tgt;
  logic        offer_valid;
  logic [31:0] offer_pc;
  logic [31:0] offer_instr;
  logic        stall;

  assign redirect_tgt = redirect_pc & ~32'h0000_0003;

  // The hold entry, when present, is always older than the memory word.
  assign offer_valid = hold_valid_q | rsp_valid_q;
  assign offer_pc    = hold_valid_q ? hold_pc_q    : rsp_pc_q;
  assign offer_instr = hold_valid_q ? hold_instr_q : imem_instruction;

  // A redirect squashes whatever is offered in the same cycle.
  assign id_valid = offer_valid & ~redirect_valid;
  assign id_pc    = offer_pc;
  assign id_instr = id_valid ? offer_instr : NOP_INSTR;

  assign stall = id_valid & ~id_ready;

`ifdef FETCH_FAST_REDIRECT_EN
  assign imem_addr = redirect_valid ? redirect_tgt : pc_q;
`else
  assign imem_addr = pc_q;
`endif

  always_comb begin
    pc_d         = pc_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_pc_d     = rsp_pc_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;

    if (redirect_valid) begin
      hold_valid_d = 1'b0;
`ifdef FETCH_FAST_REDIRECT_EN
      // The target was already issued this cycle; it returns next cycle.
      pc_d        = redirect_tgt + 32'd4;
      rsp_pc_d    = redirect_tgt;
      rsp_valid_d = 1'b1;
`else
      pc_d        = redirect_tgt;
      rsp_valid_d = 1'b0;
`endif
    end else if (stall) begin
      // pc_q is re-issued so the word at pc_q is back in flight when the
      // stall releases; the offered word parks in the hold entry.
      rsp_pc_d    = pc_q;
      rsp_valid_d = 1'b1;
      if (!hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_pc_d    = offer_pc;
        hold_instr_d = offer_instr;
      end
    end else begin
      pc_d         = pc_q + 32'd4;
      rsp_pc_d     = pc_q;
      rsp_valid_d  = 1'b1;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      rsp_valid_q  <= 1'b0;
      rsp_pc_q     <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
    end else begin
      pc_q         <= pc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_pc_q     <= rsp_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A behavioural synchronous-read memory holds
// word 0x100+i at word index i. Expected {pc, instr} pairs are queued ahead of
// time and popped on every id_valid && id_ready transfer; a redirect or reset
// discards the wrong-path expectations and queues the new stream.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_FAST_REDIRECT_EN
  localparam int REDIR_BUBBLES = 0;
`else
  localparam int REDIR_BUBBLES = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_pc            (id_pc),
    .id_instr         (id_instr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  always @(posedge clk) imem_instruction <= mem_word(imem_addr);

  // scoreboard
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  logic        obs_valid;
  logic [31:0] obs_pc, obs_instr, obs_addr;
  logic        prev_stall;
  logic [31:0] prev_pc, prev_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back({pc, mem_word(pc)});
    end
  endtask

  // driver: one cycle, inputs applied at negedge, outputs sampled 1 later
  task automatic do_cycle(input logic rst, input logic rdy, input logic rv,
                          input logic [31:0] rpc);
    logic [63:0] e;
    @(negedge clk);
    rst_n          = rst;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    obs_valid = id_valid;
    obs_pc    = id_pc;
    obs_instr = id_instr;
    obs_addr  = imem_addr;
    if (prev_stall && !rv) begin
      check("stall_stable_valid", {31'b0, id_valid}, 32'd1);
      check("stall_stable_pc", id_pc, prev_pc);
      check("stall_stable_instr", id_instr, prev_instr);
    end
    if (id_valid && id_ready) begin
      check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", id_pc, e[63:32]);
        check("sb_instr", id_instr, e[31:0]);
      end
    end
    prev_stall = rst && id_valid && !id_ready;
    prev_pc    = id_pc;
    prev_instr = id_instr;
  endtask

  // Runs with id_ready=1 until an offer appears (bounded), checking how many
  // bubbles preceded it and which PC it carries.
  task automatic wait_offer(input string tag, input int exp_bubbles, input logic [31:0] exp_pc);
    int b;
    bit got;
    b   = 0;
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (obs_valid) begin
        got = 1'b1;
        break;
      end
      b++;
    end
    check({tag, "_seen"}, {31'b0, got}, 32'd1);
    check({tag, "_bubbles"}, 32'(b), 32'(exp_bubbles));
    check({tag, "_pc"}, obs_pc, exp_pc);
  endtask

  initial begin
    rst_n          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    prev_stall     = 1'b0;

    // reset state
    do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    do_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("rst_addr", obs_addr, 32'h0);
    check("rst_valid", {31'b0, obs_valid}, 32'd0);
    check("rst_pc", obs_pc, 32'h0);
    check("rst_instr", obs_instr, NOP);

    // first fetch: cycle 0 issues, cycle 1 offers
    push_run(32'h0, 16);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("c0_valid", {31'b0, obs_valid}, 32'd0);
    check("c0_addr", obs_addr, 32'h0);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("c1_pc", obs_pc, 32'h0);
    check("c1_instr", obs_instr, 32'h100);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("c2_pc", obs_pc, 32'h4);

    // three-cycle stall on PC 8, then release
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("stall_pc", obs_pc, 32'h8);
      check("stall_instr", obs_instr, 32'h102);
    end
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("release_pc", obs_pc, 32'h8);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("after_release_pc", obs_pc, 32'hC);
    check("after_release_instr", obs_instr, 32'h103);

    // redirect to 0x43 while PC 16 is offered
    do_cycle(1'b1, 1'b1, 1'b1, 32'h43);
    check("squash_valid", {31'b0, obs_valid}, 32'd0);
    check("squash_instr", obs_instr, NOP);
    exp_q.delete();
    push_run(32'h40, 8);
    wait_offer("redir", REDIR_BUBBLES, 32'h40);
    check("redir_instr", obs_instr, 32'h110);

    // redirect to 0x20 while stalled with the hold entry full
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall2_pc", obs_pc, 32'h48);
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    do_cycle(1'b1, 1'b0, 1'b1, 32'h20);
    check("stall_redir_valid", {31'b0, obs_valid}, 32'd0);
    exp_q.delete();
    push_run(32'h20, 40);
    wait_offer("stall_redir", REDIR_BUBBLES, 32'h20);

    // random back-pressure; scoreboard catches loss or duplication
    for (int i = 0; i < 24; i++)
      do_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0);

    // reset mid-stall
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    exp_q.delete();
    push_run(32'h0, 8);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("midrst_valid", {31'b0, obs_valid}, 32'd0);
    check("midrst_addr", obs_addr, 32'h0);
    check("midrst_instr", obs_instr, NOP);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("midrst_first_pc", obs_pc, 32'h0);

    // wrap through the top of the address space
    do_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    exp_q.delete();
    push_run(32'hFFFF_FFFC, 8);
    wait_offer("wrap", REDIR_BUBBLES, 32'hFFFF_FFFC);
    check("wrap_top_instr", obs_instr, 32'h4000_00FF);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_zero_pc", obs_pc, 32'h0);
    check("wrap_zero_instr", obs_instr, 32'h100);
    do_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_next_pc", obs_pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: owns the program counter, drives the address of the synchronous-read instruction memory, and aligns the returned word with its PC for decode. It absorbs the memory's one-cycle read latency and decode back-pressure with a one-entry hold buffer, and squashes wrong-path fetches on a branch or jump redirect from execute. It sits between the hazard/branch logic and the IF/ID boundary, directly upstream of `instruction_memory`.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `NOP_INSTR`, 32'h0000_0013: word driven on `id_instr` whenever `id_valid`=0 (`addi x0,x0,0`).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_addr` out 32: address to `instruction_memory`, sampled by it on the rising edge.
- `imem_instruction` in 32: memory read data; equals the word at the `imem_addr` presented in the previous cycle.
- `redirect_valid` in 1: execute resolved a taken branch or jump this cycle.
- `redirect_pc` in 32: target; bits [1:0] ignored and treated as 0.
- `id_valid` out 1: `id_pc`/`id_instr` hold a live instruction.
- `id_ready` in 1: decode accepts this cycle; transfer when `id_valid && id_ready`.
- `id_pc` out 32: PC of the offered instruction.
- `id_instr` out 32: offered instruction.

## Operation
- State: `pc_q` (next address to issue), `rsp_valid_q`/`rsp_pc_q` (tags the in-flight memory word), `hold_valid_q`/`hold_pc_q`/`hold_instr_q` (skid entry).
- `imem_addr` = `pc_q`.
- Offer: if `hold_valid_q`, offer hold entry; else offer `imem_instruction` with `rsp_pc_q` when `rsp_valid_q`.
- `stall` = `id_valid && !id_ready`.
- Normal cycle (no redirect, no stall): `pc_q` <= `pc_q`+4; `rsp_pc_q` <= `pc_q`; `rsp_valid_q` <= 1; `hold_valid_q` <= 0.
- Stall: `pc_q` holds; `rsp_pc_q` <= `pc_q`; `rsp_valid_q` <= 1. If `hold_valid_q`=0, capture the offered word and PC into the hold entry and set `hold_valid_q`; if already set, the hold entry is unchanged.
- Stall release: the hold entry is transferred; the next cycle offers the word at the held `pc_q`. No instruction is lost or duplicated.
- Redirect (highest priority after reset): `id_valid` is forced 0 in the redirect cycle (the offered word is squashed, no transfer); `pc_q` <= `redirect_pc & ~3`; `rsp_valid_q` <= 0; `hold_valid_q` <= 0. This applies even while stalled.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- `id_instr` = `NOP_INSTR` whenever `id_valid`=0.

## Timing
- Reset (`rst_n`=0 at an edge): `pc_q`=`RESET_PC`, `rsp_valid_q`=0, `hold_valid_q`=0, `rsp_pc_q`=`RESET_PC`.
- After reset, outputs are `imem_addr`=`RESET_PC`, `id_valid`=0, `id_pc`=`RESET_PC`, `id_instr`=`NOP_INSTR`.
- Reset takes effect mid-stall or mid-redirect; it overrides everything.
- First valid instruction appears 1 cycle after reset release: cycle 0 issues `RESET_PC`, and cycle 1 offers it.
- Steady state: throughput is one instruction per cycle. Fetch-to-offer latency is 1 cycle.
- Redirect penalty is 2 cycles with `id_valid`=0: the redirect cycle and the following cycle. The target is offered 2 cycles after the redirect.
- With `id_ready` stuck at 0, `id_valid`, `id_pc` and `id_instr` stay stable until transfer.

## Configuration
- `FETCH_FAST_REDIRECT_EN` defined: `imem_addr` = `redirect_valid ? redirect_pc & ~3 : pc_q`.
  - On redirect: `pc_q` <= target+4, `rsp_pc_q` <= target, `rsp_valid_q` <= 1.
  - The target is offered the cycle after the redirect, so the penalty is 1 bubble. This adds a combinational path from `redirect_pc` to the memory address.
- Undefined: `imem_addr` is purely registered, and the penalty is 2 bubbles as specified above.

## Test plan
- Reset with `RESET_PC`=0 and `id_ready`=1, memory holding words 0x100+i: `id_valid`=0 in cycle 0, then PCs 0,4,8,… with instructions 0x100,0x101,… one per cycle.
- Stall for 3 cycles while PC 8 is offered, then release: PC 8/0x102 is held stable throughout, then transfers once, followed by PC 12/0x103. There is no duplicate and no gap.
- `redirect_valid`=1 with `redirect_pc`=0x43 while PC 16 is offered: PC 16 is squashed and followed by 2 invalid cycles, then PC 0x40. Repeat with `FETCH_FAST_REDIRECT_EN`: 1 invalid cycle, then 0x40.
- Redirect to 0x20 during an active stall with the hold entry full: the hold entry is discarded, and the next valid offer is PC 0x20.
- `rst_n` pulled low for 1 cycle mid-stream: the next cycle shows `id_valid`=0, `imem_addr`=`RESET_PC`, and `id_instr`=0x13.
- Redirect to 0xFFFF_FFFC: offers 0xFFFF_FFFC, then wraps to PC 0.
